// File: rtl/calc_cmd_sequencer.sv
// Host-side command driver for the queue calculator: buffers instruction words
// in a FIFO and replays them as in/op/apply strobes, halting on a calculator error.
module calc_cmd_sequencer #(
    parameter int DEPTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [11:0]              cmd_data,
    output logic                     cmd_ready,
    output logic [7:0]               calc_in,
    output logic [2:0]               calc_op,
    output logic                     calc_apply,
    input  logic [7:0]               calc_tail,
    input  logic                     calc_empty,
    input  logic                     calc_err,
    output logic                     res_valid,
    output logic [7:0]               res_data,
    output logic                     res_empty,
    output logic                     halted,
    input  logic                     clear,
    output logic [7:0]               issued,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        READ,
        HALT
    } state_t;

    state_t         state_q;
    logic [WW-1:0]  wait_q;
    logic [7:0]     calc_in_q;
    logic [2:0]     calc_op_q;
    logic           calc_apply_q;
    logic           res_valid_q;
    logic [7:0]     res_data_q;
    logic           res_empty_q;
    logic           halted_q;
    logic [7:0]     issued_q;

    logic [11:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    logic           push;
    logic           pop;
    logic           flush;
    logic [11:0]    head;

    // Ready is gated by rst so nothing is accepted while the block is held in reset.
    assign cmd_ready = rst && (count_q < CW'(DEPTH)) && !halted_q;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign flush     = (state_q == HALT) && clear;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end
    end

    // Outputs are loaded on the transition into a state so they are valid during it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            calc_in_q    <= '0;
            calc_op_q    <= '0;
            calc_apply_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_empty_q  <= 1'b0;
            halted_q     <= 1'b0;
            issued_q     <= '0;
        end else begin
            calc_apply_q <= 1'b0;
            res_valid_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        if (head[11]) begin
                            state_q <= READ;
                        end else begin
                            state_q      <= ISSUE;
                            calc_apply_q <= 1'b1;
                            calc_in_q    <= head[7:0];
                            calc_op_q    <= head[10:8];
                            issued_q     <= issued_q + 8'd1;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    wait_q  <= WW'(SETTLE - 1);
                end
                WAIT: begin
                    if (wait_q == '0) begin
                        if (calc_err) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        wait_q <= wait_q - WW'(1);
                    end
                end
                READ: begin
                    res_data_q  <= calc_tail;
                    res_empty_q <= calc_empty;
                    res_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                HALT: begin
                    if (clear) begin
                        halted_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign calc_in    = calc_in_q;
    assign calc_op    = calc_op_q;
    assign calc_apply = calc_apply_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_empty  = res_empty_q;
    assign halted     = halted_q;
    assign issued     = issued_q;
    assign fifo_count = count_q;

endmodule
